// File: rtl/zap_shift_operand_decoder_pkg.sv
// Shared definitions for the ZAP shift operand decoder: shifter opcodes,
// FSM state encoding and operand-2 field positions.
package zap_shift_pkg;

    localparam logic [2:0] OP_LSL     = 3'd0;
    localparam logic [2:0] OP_LSR     = 3'd1;
    localparam logic [2:0] OP_ASR     = 3'd2;
    localparam logic [2:0] OP_ROR     = 3'd3;
    localparam logic [2:0] OP_RORI    = 3'd4;
    localparam logic [2:0] OP_ROR_1   = 3'd5;
    localparam logic [2:0] OP_RRC     = 3'd6;
    localparam logic [2:0] OP_LSL_SAT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_RM,
        ST_RD_RS,
        ST_OUT
    } state_t;

    localparam int OP2_RM_LSB    = 0;
    localparam int OP2_REG_SHIFT = 4;
    localparam int OP2_SH_LSB    = 5;
    localparam int OP2_SHAMT_LSB = 7;
    localparam int OP2_RS_LSB    = 8;
    localparam int OP2_IMM_LSB   = 0;
    localparam int OP2_ROT_LSB   = 8;

endpackage

// File: rtl/zap_shift_operand_decoder_if.sv
// Bundle of the instruction input, register-file read port and shifter output
// handshakes. master = decoder side, slave = surrounding pipeline.
interface zap_shift_operand_decoder_if #(
    parameter int SHIFT_OPS = 8
);
    localparam int SHIFT_W = $clog2(SHIFT_OPS);

    logic               i_valid;
    logic               o_ready;
    logic               i_imm;
    logic [11:0]        i_op2;
    logic               o_rd_req;
    logic [3:0]         o_rd_addr;
    logic               i_rd_ack;
    logic [31:0]        i_rd_data;
    logic               o_valid;
    logic               i_ready;
    logic [31:0]        o_source;
    logic [7:0]         o_amount;
    logic [SHIFT_W-1:0] o_shift_type;

    modport master (
        input  i_valid, i_imm, i_op2, i_rd_ack, i_rd_data, i_ready,
        output o_ready, o_rd_req, o_rd_addr, o_valid, o_source, o_amount, o_shift_type
    );

    modport slave (
        output i_valid, i_imm, i_op2, i_rd_ack, i_rd_data, i_ready,
        input  o_ready, o_rd_req, o_rd_addr, o_valid, o_source, o_amount, o_shift_type
    );

endinterface

// File: rtl/zap_shift_operand_decoder_field_decode.sv
// Combinational resolution of the ARM operand-2 encoding into the shifter's
// {source, amount, shift_type} triple.
module zap_shift_field_decode
    import zap_shift_pkg::*;
#(
    parameter int SHIFT_OPS = 8
) (
    input  logic [11:0]                    op2,
    input  logic                           imm,
    input  logic [31:0]                    rm_data,
    input  logic [7:0]                     rs_low,
    output logic [31:0]                    source,
    output logic [7:0]                     amount,
    output logic [$clog2(SHIFT_OPS)-1:0]   shift_type
);
    localparam int SHIFT_W = $clog2(SHIFT_OPS);

    logic [1:0] sh;
    logic [4:0] shamt;

    assign sh    = op2[OP2_SH_LSB +: 2];
    assign shamt = op2[OP2_SHAMT_LSB +: 5];

    always_comb begin
        source     = rm_data;
        amount     = 8'd0;
        shift_type = SHIFT_W'(OP_LSL);
        if (imm) begin
            source     = {24'b0, op2[OP2_IMM_LSB +: 8]};
            amount     = {3'b0, op2[OP2_ROT_LSB +: 4], 1'b0};
            shift_type = SHIFT_W'(OP_RORI);
        end else if (op2[OP2_REG_SHIFT]) begin
            amount     = rs_low;
            shift_type = SHIFT_W'({1'b0, sh});
        end else begin
            // A zero immediate amount re-encodes LSR/ASR as #32 and ROR as RRX.
            case (sh)
                2'd0: begin
                    amount     = {3'b0, shamt};
                    shift_type = SHIFT_W'(OP_LSL);
                end
                2'd1, 2'd2: begin
                    amount     = (shamt == 5'd0) ? 8'd32 : {3'b0, shamt};
                    shift_type = SHIFT_W'({1'b0, sh});
                end
                default: begin
                    amount     = {3'b0, shamt};
                    shift_type = (shamt == 5'd0) ? SHIFT_W'(OP_RRC) : SHIFT_W'(OP_ROR_1);
                end
            endcase
        end
    end

endmodule

// File: rtl/zap_shift_operand_decoder.sv
// Operand-2 front end of the ZAP barrel shifter: fetches Rm/Rs through the
// register read port and presents the decoded shift triple on valid/ready.
module zap_shift_operand_decoder
    import zap_shift_pkg::*;
#(
    parameter int SHIFT_OPS = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_flush,
    zap_shift_operand_decoder_if.master   bus
);
    localparam int SHIFT_W = $clog2(SHIFT_OPS);

    state_t             state, state_nxt;
    logic [11:0]        op2_q;
    logic [31:0]        rm_q;
    logic [3:0]         rd_addr_q;
    logic [31:0]        source_q;
    logic [7:0]         amount_q;
    logic [SHIFT_W-1:0] type_q;

    logic               accept, rm_ack, rs_ack, load_out;
    logic [11:0]        dec_op2;
    logic               dec_imm;
    logic [31:0]        dec_rm;
    logic [31:0]        dec_source;
    logic [7:0]         dec_amount;
    logic [SHIFT_W-1:0] dec_type;

    assign accept   = (state == ST_IDLE) && bus.i_valid && !i_flush;
    assign rm_ack   = (state == ST_RD_RM) && bus.i_rd_ack;
    assign rs_ack   = (state == ST_RD_RS) && bus.i_rd_ack;
    assign load_out = !i_flush && ((accept && bus.i_imm) ||
                                   (rm_ack && !op2_q[OP2_REG_SHIFT]) || rs_ack);

    // The decoder sees live inputs on the accept edge and live read data on the
    // final ack edge, so the triple registers in the same cycle it resolves.
    assign dec_op2 = (state == ST_IDLE) ? bus.i_op2 : op2_q;
    assign dec_imm = (state == ST_IDLE) && bus.i_imm;
    assign dec_rm  = (state == ST_RD_RM) ? bus.i_rd_data : rm_q;

    zap_shift_field_decode #(.SHIFT_OPS(SHIFT_OPS)) u_decode (
        .op2        (dec_op2),
        .imm        (dec_imm),
        .rm_data    (dec_rm),
        .rs_low     (bus.i_rd_data[7:0]),
        .source     (dec_source),
        .amount     (dec_amount),
        .shift_type (dec_type)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.i_valid) state_nxt = bus.i_imm ? ST_OUT : ST_RD_RM;
            ST_RD_RM: if (bus.i_rd_ack) state_nxt = op2_q[OP2_REG_SHIFT] ? ST_RD_RS : ST_OUT;
            ST_RD_RS: if (bus.i_rd_ack) state_nxt = ST_OUT;
            ST_OUT:   if (bus.i_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (i_flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            rd_addr_q <= 4'd0;
            source_q  <= 32'd0;
            amount_q  <= 8'd0;
            type_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                rd_addr_q <= bus.i_op2[OP2_RM_LSB +: 4];
            else if (rm_ack)
                rd_addr_q <= op2_q[OP2_RS_LSB +: 4];
            if (load_out) begin
                source_q <= dec_source;
                amount_q <= dec_amount;
                type_q   <= dec_type;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) op2_q <= bus.i_op2;
        if (rm_ack) rm_q  <= bus.i_rd_data;
    end

    assign bus.o_ready      = (state == ST_IDLE);
    assign bus.o_valid      = (state == ST_OUT);
    assign bus.o_rd_req     = (state == ST_RD_RM) || (state == ST_RD_RS);
    assign bus.o_rd_addr    = rd_addr_q;
    assign bus.o_source     = source_q;
    assign bus.o_amount     = amount_q;
    assign bus.o_shift_type = type_q;

endmodule

// File: doc/zap_shift_operand_decoder.md
# zap_shift_operand_decoder

Upstream producer for the ZAP barrel shifter. The block accepts the 12-bit operand-2 field of a data-processing instruction and fetches the register operands it needs through a handshaked register-file read port. It resolves the ARM shift encoding, including the #0 special cases, into the shifter's `{source, amount, shift_type}` triple, and presents that triple on a valid/ready output.

## Interface

**Parameters**
- `SHIFT_OPS`, default 8: number of shifter operations; `i`/`o_shift_type` width is `$clog2(SHIFT_OPS)`, which is 3.

**Ports**
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  reset, synchronous and active-high.
- `i_flush`  in  1  synchronous abort; returns the block to IDLE.
- `i_valid`  in  1  instruction operand field valid.
- `o_ready`  out  1  block can accept; high only in IDLE.
- `i_imm`  in  1  I bit; 1 selects rotated immediate.
- `i_op2`  in  12  operand-2 field.
- `o_rd_req`  out  1  register read request.
- `o_rd_addr`  out  4  register index.
- `i_rd_ack`  in  1  read complete; `i_rd_data` is valid in the same cycle.
- `i_rd_data`  in  32  read data.
- `o_valid`  out  1  output triple valid.
- `i_ready`  in  1  shifter accepts the triple.
- `o_source`  out  32  value to shift.
- `o_amount`  out  8  shift amount.
- `o_shift_type`  out  3  shifter op code.

## Operation

- **Acceptance:** a transfer happens when `i_valid & o_ready` is high. The input fields are captured on that edge.
- **Immediate form (`i_imm=1`):**
  - `o_source = {24'b0, op2[7:0]}`
  - `o_amount = {3'b0, op2[11:8], 1'b0}`
  - type = RORI
  - No register read is made.
- **Immediate-shift form (`i_imm=0`, `op2[4]=0`):** read Rm = `op2[3:0]`; shamt = `op2[11:7]`; sh = `op2[6:5]`.
  - LSL: amount = shamt.
  - LSR/ASR with shamt=0: amount = 32. With shamt≠0: amount = shamt.
  - ROR with shamt=0: type = RRC, amount = 0.
  - ROR with shamt≠0: type = ROR_1, amount = shamt.
- **Register-shift form (`i_imm=0`, `op2[4]=1`):**
  - Read Rm first, then Rs = `op2[11:8]`.
  - amount = `Rs[7:0]`; type = `{1'b0, sh}`.
  - `op2[7]` is ignored; upstream guarantees it is 0.
- **Opcodes:** LSL=0, LSR=1, ASR=2, ROR=3, RORI=4, ROR_1=5, RRC=6, LSL_SAT=7. This block never emits LSL_SAT.
- **FSM states:** IDLE, RD_RM, RD_RS, OUT.
  - IDLE → OUT on accept with `i_imm=1`.
  - IDLE → RD_RM on accept with `i_imm=0`.
  - RD_RM → OUT on `i_rd_ack` if `op2[4]=0`; RD_RM → RD_RS on `i_rd_ack` if `op2[4]=1`.
  - RD_RS → OUT on `i_rd_ack`.
  - OUT → IDLE on `i_ready`.
- **Read port:**
  - `o_rd_req` is high throughout RD_RM and RD_RS.
  - `o_rd_addr` is stable while `o_rd_req` is high.
  - Data is captured on the ack edge.
  - An ack seen while not requesting is ignored.
- **Flush:** `i_flush` forces IDLE from any state, with `o_valid=0` and `o_rd_req=0` on the next cycle. Flush in the same cycle as `i_valid` means the instruction is not accepted. Flush in OUT in the same cycle as `i_ready`: the transfer counts, and the state is IDLE either way.
- **Reset:**
  - State = IDLE.
  - `o_valid=0`, `o_rd_req=0`, `o_rd_addr=0`.
  - `o_source=0`, `o_amount=0`, `o_shift_type=0`.
  - `o_ready` is 1 after reset deasserts.
  - Reset mid-read drops the request with no further handshake.

## Timing

- **Latency from accept edge to `o_valid`:**
  - Immediate: 1 cycle.
  - Immediate-shift: 1 cycle + Rm ack wait.
  - Register-shift: 1 cycle + Rm ack wait + Rs ack wait.
  - Zero-wait acks (ack in the first request cycle) give 2 and 3 cycles for the register forms.
- **Output hold:** `o_source`, `o_amount` and `o_shift_type` are registered and held stable while `o_valid & ~i_ready`.
- **No back-to-back overlap:** the next accept can occur, at the earliest, in the cycle after the OUT handshake. Sustained throughput is 1 instruction per 2 cycles in immediate form.
- **All outputs are registered.** `o_ready` is a decode of the state register only.

## Structure

- A shared package `zap_shift_pkg` holds:
  - the shift opcode constants (including LSL_SAT);
  - the FSM state enum;
  - the field-position constants for `op2`.
- Sub-module `zap_shift_field_decode` is combinational: `op2`, `i_imm`, Rm data and Rs data in; source, amount and type out. The FSM wrapper registers its result on the final ack edge, or on the accept edge for the immediate form.

## Test plan

- **Immediate, op2=0x4FF:** `i_imm=1`, `op2=0x4FF` → one cycle later `o_valid=1`, `o_source=0xFF`, `o_amount=8`, type=4; `o_rd_req` never asserts.
- **LSR #0:** `op2=0x023`, Rm=3 data 0x80000000, ack after 2 wait cycles → `o_rd_addr=3`; output source 0x80000000, amount 32, type 1.
- **Register ASR:** `op2=0x255`, Rm=5 data 0xF0000000, Rs=2 data 0x00000124, zero-wait acks → addr 5 then 2; output amount 0x24, type 2, `o_valid` 3 cycles after accept.
- **ROR #0 / ROR #n:** `op2=0x060` → type 6, amount 0. `op2=0x3E0` → type 5, amount 7.
- **Backpressure:** hold `i_ready=0` for 5 cycles in OUT → outputs stable and `o_ready=0`; `i_ready=1` → IDLE next cycle.
- **Flush and reset mid-read:**
  - `i_flush` in RD_RS with no ack → `o_rd_req=0`, IDLE next cycle, no `o_valid`.
  - Repeat with `i_reset` → all outputs 0.
  - Flush in the same cycle as `i_valid` → nothing accepted.
